// File: rtl/repvgg_pkg.sv
// ---------------------------------------------------------------------------
// repvgg_pkg
// Shared definitions for the RepVGG line-buffer input stage: default pixel
// width, 3x3 kernel geometry, the line-buffer FSM state encoding and the
// helper that maps a window element (row i, column j) to its bit offset.
// ---------------------------------------------------------------------------
package repvgg_pkg;

   // Default bits per pixel (one channel-group word per beat)
   localparam int DEF_DATA_W = 8;

   // Kernel size and number of elements in one window
   localparam int K     = 3;
   localparam int WIN_N = K * K;

   // Line-buffer control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } lb_state_e;

   // Bit offset of window element (i = row, 0 oldest; j = column, 0 leftmost)
   function automatic int win_lsb(input int i, input int j, input int dw);
      return ((K * i) + j) * dw;
   endfunction

endpackage

// File: rtl/repvgg_line_mem.sv
// ---------------------------------------------------------------------------
// repvgg_line_mem
// One line memory of DEPTH x DATA_W. A single address serves both the read
// and the write of an access; the read is combinational, so the value seen
// during a write cycle is the old contents (read-before-write).
// Ports:
//   clk    clock
//   we     write enable for this cycle
//   addr   shared read/write address (column index)
//   wdata  data written at addr on the rising edge when we is high
//   rdata  current contents at addr
// ---------------------------------------------------------------------------
module repvgg_line_mem
   import repvgg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   // Contents are don't-care after reset, so the array carries no reset
   logic [DATA_W-1:0] mem_r [DEPTH];

   // Write port: store the new column value on accepted pixels
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   assign rdata = mem_r[addr];

endmodule

// File: rtl/repvgg_line_buffer.sv
// ---------------------------------------------------------------------------
// repvgg_line_buffer
// Turns a raster-order pixel stream into 3x3 sliding windows (stride 1, no
// padding). Two line memories hold the previous two rows; a 3x3 register
// window shifts left on every accepted pixel and doubles as the output
// register, so a window appears one cycle after the pixel that completes it.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle pulse: latch cfg_width/cfg_height
//   cfg_width, cfg_height   frame size W (3..MAX_W) and H (>=3)
//   busy                    high from accepted start until frame_done
//   cfg_err                 one-cycle pulse on a start with illegal config
//   in_valid/in_ready/in_data        pixel stream input
//   win_valid/win_ready/win_data     3x3 window output
//   frame_done              one-cycle pulse after the last window is taken
// ---------------------------------------------------------------------------
module repvgg_line_buffer
   import repvgg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int MAX_W  = 64,
   parameter int DIM_W  = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [DIM_W-1:0]        cfg_width,
   input  logic [DIM_W-1:0]        cfg_height,
   output logic                    busy,
   output logic                    cfg_err,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic [WIN_N*DATA_W-1:0] win_data,
   output logic                    frame_done
);

   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [DIM_W-1:0] MAX_W_C   = DIM_W'(MAX_W);
   localparam logic [DIM_W-1:0] MIN_DIM_C = DIM_W'(K);
   localparam logic [DIM_W-1:0] ONE_C     = DIM_W'(1);
   localparam logic [DIM_W-1:0] TWO_C     = DIM_W'(2);

   lb_state_e state_r;
   lb_state_e state_next_s;

   logic [DIM_W-1:0]        width_r;
   logic [DIM_W-1:0]        height_r;
   logic [DIM_W-1:0]        row_r;
   logic [DIM_W-1:0]        col_r;
   logic                    busy_r;
   logic                    cfg_err_r;
   logic                    frame_done_r;
   logic                    win_valid_r;
   logic [WIN_N*DATA_W-1:0] win_r;
   logic [WIN_N*DATA_W-1:0] win_shift_s;

   logic                    cfg_ok_s;
   logic                    in_ready_s;
   logic                    accept_s;
   logic                    col_wrap_s;
   logic                    last_pix_s;
   logic                    win_load_s;
   logic                    drain_ok_s;
   logic [AW-1:0]           addr_s;
   logic [DATA_W-1:0]       mem_a_rd_s;
   logic [DATA_W-1:0]       mem_b_rd_s;

   // Handshake and frame-position decode for the current cycle
   always_comb begin
      cfg_ok_s   = (cfg_width >= MIN_DIM_C) && (cfg_width <= MAX_W_C) &&
                   (cfg_height >= MIN_DIM_C);
      // Output register may be refilled when empty or being drained this cycle
      in_ready_s = (state_r == ST_RUN) && (!win_valid_r || win_ready);
      accept_s   = in_valid && in_ready_s;
      col_wrap_s = (col_r == (width_r - ONE_C));
      last_pix_s = col_wrap_s && (row_r == (height_r - ONE_C));
      // Columns 0/1 of a row would mix in the previous row's tail: never emit
      win_load_s = accept_s && (row_r >= TWO_C) && (col_r >= TWO_C);
      drain_ok_s = !win_valid_r || win_ready;
      addr_s     = AW'(col_r);
   end

   // Next-state logic of the frame controller
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && cfg_ok_s) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_s && last_pix_s) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_ok_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Frame controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Config latch, row/column counters and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_r      <= '0;
         height_r     <= '0;
         row_r        <= '0;
         col_r        <= '0;
         busy_r       <= 1'b0;
         cfg_err_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         cfg_err_r    <= 1'b0;
         frame_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_ok_s) begin
                     width_r  <= cfg_width;
                     height_r <= cfg_height;
                     row_r    <= '0;
                     col_r    <= '0;
                     busy_r   <= 1'b1;
                  end else begin
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (accept_s) begin
                  if (col_wrap_s) begin
                     col_r <= '0;
                     row_r <= row_r + ONE_C;
                  end else begin
                     col_r <= col_r + ONE_C;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_ok_s) begin
                  frame_done_r <= 1'b1;
               end
            end
            ST_DONE: begin
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // Shift the window one column left; new right column is {A[c], B[c], pixel}
   always_comb begin
      win_shift_s = win_r;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K - 1; j++) begin
            win_shift_s[win_lsb(i, j, DATA_W) +: DATA_W] =
               win_r[win_lsb(i, j + 1, DATA_W) +: DATA_W];
         end
      end
      win_shift_s[win_lsb(0, K - 1, DATA_W) +: DATA_W] = mem_a_rd_s;
      win_shift_s[win_lsb(1, K - 1, DATA_W) +: DATA_W] = mem_b_rd_s;
      win_shift_s[win_lsb(2, K - 1, DATA_W) +: DATA_W] = in_data;
   end

   // Window register and its valid flag. The window only shifts on accept,
   // and accept is blocked while a window is held, so a stalled window is
   // never disturbed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid_r <= 1'b0;
         win_r       <= '0;
      end else begin
         if (win_load_s) begin
            win_valid_r <= 1'b1;
         end else if (win_ready) begin
            win_valid_r <= 1'b0;
         end
         if (accept_s) begin
            win_r <= win_shift_s;
         end
      end
   end

   // Line A holds row r-2 and is refilled from line B (row r-1)
   repvgg_line_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_W),
      .ADDR_W (AW)
   ) u_mem_a (
      .clk   (clk),
      .we    (accept_s),
      .addr  (addr_s),
      .wdata (mem_b_rd_s),
      .rdata (mem_a_rd_s)
   );

   // Line B holds row r-1 and is refilled with the incoming pixel
   repvgg_line_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_W),
      .ADDR_W (AW)
   ) u_mem_b (
      .clk   (clk),
      .we    (accept_s),
      .addr  (addr_s),
      .wdata (in_data),
      .rdata (mem_b_rd_s)
   );

   assign busy       = busy_r;
   assign cfg_err    = cfg_err_r;
   assign in_ready   = in_ready_s;
   assign win_valid  = win_valid_r;
   assign win_data   = win_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_repvgg_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_repvgg_line_buffer
// Self-checking bench: table of illegal configs, table of frames (sizes,
// pixel patterns, backpressure and gap styles) compared against windows
// computed directly from a pixel array, plus hand sequences for mid-frame
// reset.
// ---------------------------------------------------------------------------
module tb_repvgg_line_buffer;

   localparam int DW  = 8;
   localparam int MW  = 64;
   localparam int DMW = 7;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [DMW-1:0]    cfg_width;
   logic [DMW-1:0]    cfg_height;
   logic              busy;
   logic              cfg_err;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic              win_valid;
   logic              win_ready;
   logic [9*DW-1:0]   win_data;
   logic              frame_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int w;
      int h;
      bit err;
   } cfg_vec_t;

   typedef struct {
      int w;
      int h;
      int kind;   // 0: p=r*W+c, 1: p=r*W+c+1, 2: random
      int rmode;  // 0: always ready, 1: toggling, 2: random
      bit gaps;
      bit poke;   // pulse an illegal start mid-frame
      int nwin;
   } frame_vec_t;

   repvgg_line_buffer #(
      .DATA_W (DW),
      .MAX_W  (MW),
      .DIM_W  (DMW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .busy       (busy),
      .cfg_err    (cfg_err),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [9*DW-1:0] act,
                        input logic [9*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk_i({tag, "_busy"}, int'(busy), 0);
      chk_i({tag, "_cfg_err"}, int'(cfg_err), 0);
      chk_i({tag, "_in_ready"}, int'(in_ready), 0);
      chk_i({tag, "_win_valid"}, int'(win_valid), 0);
      chk_i({tag, "_frame_done"}, int'(frame_done), 0);
      chk_w({tag, "_win_data"}, win_data, '0);
   endtask

   // Run one full frame; entered and left at posedge+1
   task automatic run_frame(input frame_vec_t fv);
      logic [DW-1:0]   pix[$];
      logic [9*DW-1:0] expq[$];
      logic [9*DW-1:0] wv;
      logic [9*DW-1:0] prev_data;
      int n, k, cyc, acc_cyc, got, dones, done_cyc;
      bit prev_stall, seen_first, finished;

      n = fv.w * fv.h;
      for (int p = 0; p < n; p++) begin
         case (fv.kind)
            0:       pix.push_back(DW'(p));
            1:       pix.push_back(DW'(p + 1));
            default: pix.push_back(DW'($urandom));
         endcase
      end
      // Reference windows straight from the pixel array
      for (int r = 2; r < fv.h; r++) begin
         for (int c = 2; c < fv.w; c++) begin
            wv = '0;
            for (int i = 0; i < 3; i++) begin
               for (int j = 0; j < 3; j++) begin
                  wv[(3*i + j)*DW +: DW] = pix[(r - 2 + i)*fv.w + (c - 2 + j)];
               end
            end
            expq.push_back(wv);
         end
      end
      chk_i("model_window_count", expq.size(), fv.nwin);

      cfg_width  = DMW'(fv.w);
      cfg_height = DMW'(fv.h);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk_i("busy_after_start", int'(busy), 1);
      chk_i("no_cfg_err_legal", int'(cfg_err), 0);

      k = 0; cyc = 0; acc_cyc = -10; got = 0; dones = 0; done_cyc = 0;
      prev_stall = 1'b0; seen_first = 1'b0; finished = 1'b0; prev_data = '0;
      while (!finished && cyc < 5000) begin
         in_valid = (k < n) && (!fv.gaps || ($urandom_range(0, 3) != 0));
         in_data  = (k < n) ? pix[k] : '0;
         case (fv.rmode)
            0:       win_ready = 1'b1;
            1:       win_ready = (cyc % 2 == 0);
            default: win_ready = ($urandom_range(0, 1) == 1);
         endcase
         if (fv.poke && cyc == 3) begin
            start     = 1'b1;
            cfg_width = DMW'(2);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (prev_stall) begin
            chk_i("stall_hold_valid", int'(win_valid), 1);
            chk_w("stall_hold_data", win_data, prev_data);
         end
         if (win_valid && !seen_first) begin
            seen_first = 1'b1;
            chk_i("first_window_latency", cyc, acc_cyc + 1);
         end
         if (win_valid && !win_ready) chk_i("ready_while_full", int'(in_ready), 0);
         if (k == n) chk_i("ready_after_last", int'(in_ready), 0);
         if (cfg_err) chk_i("spurious_cfg_err", int'(cfg_err), 0);
         if (dones == 0) chk_i("busy_in_frame", int'(busy), 1);
         if (win_valid && win_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_window actual=%h required=none", win_data);
            end else begin
               chk_w("window", win_data, expq.pop_front());
            end
            got++;
         end
         if (dones > 0 && cyc == done_cyc + 1) begin
            chk_i("done_pulse_len", int'(frame_done), 0);
            chk_i("busy_fall", int'(busy), 0);
            finished = 1'b1;
         end
         if (frame_done) begin
            dones++;
            done_cyc = cyc;
            chk_i("done_all_consumed", expq.size(), 0);
         end
         if (in_valid && in_ready) begin
            if (k == 2*fv.w + 2) acc_cyc = cyc;
            k++;
         end
         prev_stall = win_valid && !win_ready;
         prev_data  = win_data;
         @(posedge clk); #1;
         cyc++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout actual=%0d cycles required=frame_done", cyc);
      end
      chk_i("window_count", got, fv.nwin);
      chk_i("done_count", dones, 1);
      chk_i("pixels_accepted", k, n);
   endtask

   // Start a 4x4 frame, feed npix pixels, then pulse rst_n low
   task automatic reset_mid(input int npix, input bit rdy);
      int k, cyc;
      cfg_width  = DMW'(4);
      cfg_height = DMW'(4);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0; cyc = 0;
      while (k < npix && cyc < 200) begin
         in_valid  = 1'b1;
         in_data   = DW'(k + 100);
         win_ready = rdy;
         @(negedge clk);
         if (in_ready) k++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      chk_i("pre_reset_pixels", k, npix);
      if (!rdy) chk_i("pre_reset_window_held", int'(win_valid), 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("post_reset");
   endtask

   cfg_vec_t   cv[6];
   frame_vec_t fvt[5];
   frame_vec_t ref4;

   initial begin
      cv[0] = '{w: 2,   h: 4,   err: 1'b1};
      cv[1] = '{w: 65,  h: 4,   err: 1'b1};
      cv[2] = '{w: 4,   h: 2,   err: 1'b1};
      cv[3] = '{w: 0,   h: 3,   err: 1'b1};
      cv[4] = '{w: 3,   h: 0,   err: 1'b1};
      cv[5] = '{w: 127, h: 127, err: 1'b1};

      fvt[0] = '{w: 4,  h: 4, kind: 0, rmode: 0, gaps: 1'b0, poke: 1'b0, nwin: 4};
      fvt[1] = '{w: 4,  h: 4, kind: 0, rmode: 1, gaps: 1'b1, poke: 1'b0, nwin: 4};
      fvt[2] = '{w: 3,  h: 3, kind: 1, rmode: 0, gaps: 1'b0, poke: 1'b0, nwin: 1};
      fvt[3] = '{w: 64, h: 3, kind: 2, rmode: 2, gaps: 1'b1, poke: 1'b0, nwin: 62};
      fvt[4] = '{w: 5,  h: 4, kind: 2, rmode: 0, gaps: 1'b0, poke: 1'b1, nwin: 6};
      ref4   = fvt[0];

      rst_n      = 1'b1;
      start      = 1'b0;
      cfg_width  = '0;
      cfg_height = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      win_ready  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Illegal configurations: pulse cfg_err, stay idle
      for (int t = 0; t < 6; t++) begin
         cfg_width  = DMW'(cv[t].w);
         cfg_height = DMW'(cv[t].h);
         start      = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk_i("cfg_err_pulse", int'(cfg_err), int'(cv[t].err));
         chk_i("cfg_err_busy", int'(busy), 0);
         chk_i("cfg_err_in_ready", int'(in_ready), 0);
         @(posedge clk); #1;
         chk_i("cfg_err_width", int'(cfg_err), 0);
         chk_i("cfg_err_busy_after", int'(busy), 0);
      end

      // Frames, back to back
      for (int t = 0; t < 5; t++) begin
         run_frame(fvt[t]);
      end

      // Mid-frame resets, each followed by a clean reference frame
      reset_mid(7, 1'b1);
      run_frame(ref4);
      reset_mid(11, 1'b0);
      run_frame(ref4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
